// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Command sequencer for the 8-bit shift register datapath. Takes one command
// at a time over valid/ready. Optionally parallel-loads the register, then
// drives the command's operation code for `count` cycles. Finishes with a
// one-cycle done pulse and a registered snapshot of sr_q.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake; ready only in IDLE
//   cmd_op/count/load/data/sin : command fields, latched on accept
//   abort             : ends the shift phase after the current cycle
//   sr_op/data/shift_in : drive the shift register's control/data pins
//   sr_q, sr_shift_out  : shift register outputs
//   busy, done, aborted : status; aborted qualifies done
//   result, result_valid : sr_q snapshot taken on the edge ending DONE
//   cap_bits          : serial-out history, one bit per shift cycle
//
// Build option
//   SHIFT_SEQ_CAPTURE_EN : when defined, the cap_bits capture register is
//                          present; otherwise cap_bits is tied to zero.
module shift_seq_ctrl #(
    parameter logic [2:0] OP_HOLD = 3'b000,
    parameter logic [2:0] OP_LOAD = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [3:0]  cmd_count,
    input  logic        cmd_load,
    input  logic [7:0]  cmd_data,
    input  logic        cmd_sin,
    input  logic        abort,
    output logic [2:0]  sr_op,
    output logic [7:0]  sr_data,
    output logic        sr_shift_in,
    input  logic [7:0]  sr_q,
    input  logic        sr_shift_out,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic [15:0] cap_bits
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] op_q;
    logic [3:0] cnt_q;
    logic [3:0] rem_q;
    logic [7:0] data_q;
    logic       sin_q;
    logic       abort_q;
    logic       accept;

    // Accept is qualified by !rst so cmd_ready reads 0 while reset is held.
    assign accept  = (state == S_IDLE) && cmd_valid && !rst;
    assign sr_data = data_q;

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        aborted     = 1'b0;
        sr_op       = OP_HOLD;
        sr_shift_in = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !rst;
                busy      = 1'b0;
                if (accept)
                    state_nxt = cmd_load ? S_LOAD :
                                (cmd_count != 4'd0) ? S_SHIFT : S_DONE;
            end
            S_LOAD: begin
                sr_op     = OP_LOAD;
                state_nxt = (cnt_q != 4'd0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                sr_op       = op_q;
                sr_shift_in = sin_q;
                // rem_q counts the cycles left including this one
                if (abort || rem_q == 4'd1)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                aborted   = abort_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= 3'd0;
            cnt_q        <= 4'd0;
            rem_q        <= 4'd0;
            data_q       <= 8'd0;
            sin_q        <= 1'b0;
            abort_q      <= 1'b0;
            result       <= 8'd0;
            result_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q         <= cmd_op;
                cnt_q        <= cmd_count;
                data_q       <= cmd_data;
                sin_q        <= cmd_sin;
                abort_q      <= 1'b0;
                result_valid <= 1'b0;
            end
            // Remaining counter: loaded on SHIFT entry from whichever count
            // is current (the input when coming from IDLE, the latch after LOAD).
            if (state != S_SHIFT && state_nxt == S_SHIFT)
                rem_q <= (state == S_IDLE) ? cmd_count : cnt_q;
            else if (state == S_SHIFT)
                rem_q <= rem_q - 4'd1;
            if (state == S_SHIFT && abort)
                abort_q <= 1'b1;
            if (state == S_DONE) begin
                result       <= sr_q;
                result_valid <= 1'b1;
            end
        end
    end

`ifdef SHIFT_SEQ_CAPTURE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cap_bits <= 16'h0000;
        else if (accept)
            cap_bits <= 16'h0000;
        else if (state == S_SHIFT)
            cap_bits <= {cap_bits[14:0], sr_shift_out};
    end
`else
    logic unused_shift_out;
    assign unused_shift_out = sr_shift_out;
    assign cap_bits         = 16'h0000;
`endif

endmodule
